// File: rtl/viterbi_pkg.sv
// Shared types, constants and helpers for the 8-state (K=4, rate-1/2)
// Viterbi ACS scheduler.
package viterbi_pkg;

   localparam int NUM_STATES = 8;
   localparam int PM_W       = 8;
   localparam int IDX_W      = 3;

   // Generator polynomials applied to r = {u, p}
   localparam logic [3:0] GEN_0 = 4'b1111;
   localparam logic [3:0] GEN_1 = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_COMMIT = 2'd2,
      S_DONE   = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic            valid;
      logic [PM_W-1:0] cost;
   } metric_t;

   // Expected encoder output for a transition out of state p with input bit u
   function automatic logic [1:0] exp_sym(input logic [IDX_W-1:0] p, input logic u);
      logic [3:0] r;
      r = {u, p};
      return {^(r & GEN_0), ^(r & GEN_1)};
   endfunction

   // Frame-start metric: only state 0 is reachable, all costs zero
   function automatic metric_t init_metric(input int unsigned s);
      metric_t m;
      m.valid = (s == 32'd0);
      m.cost  = 8'h00;
      return m;
   endfunction

endpackage

// File: rtl/acs_scheduler_if.sv
// Handshake, ACS drive and survivor bus of the ACS scheduler.
// The scheduler uses the slave modport; its environment (branch-metric
// unit, external ACS and traceback) uses the master modport.
interface acs_scheduler_if;
   import viterbi_pkg::*;

   logic                  start;
   logic                  step_valid;
   logic                  step_ready;
   logic [3:0][1:0]       bm_i;

   logic                  acs_path_0_valid;
   logic                  acs_path_1_valid;
   logic [1:0]            acs_path_0_bmc;
   logic [1:0]            acs_path_1_bmc;
   logic [PM_W-1:0]       acs_path_0_pmc;
   logic [PM_W-1:0]       acs_path_1_pmc;
   logic                  acs_selection;
   logic                  acs_valid_o;
   logic [PM_W-1:0]       acs_path_cost;

   logic                  surv_valid;
   logic                  surv_ready;
   logic [NUM_STATES-1:0] surv_sel;
   logic [NUM_STATES-1:0] surv_vld;
   logic [IDX_W-1:0]      best_state;

   modport slave (
      input  start, step_valid, bm_i,
      input  acs_selection, acs_valid_o, acs_path_cost,
      input  surv_ready,
      output step_ready,
      output acs_path_0_valid, acs_path_1_valid,
      output acs_path_0_bmc, acs_path_1_bmc,
      output acs_path_0_pmc, acs_path_1_pmc,
      output surv_valid, surv_sel, surv_vld, best_state
   );

   modport master (
      output start, step_valid, bm_i,
      output acs_selection, acs_valid_o, acs_path_cost,
      output surv_ready,
      input  step_ready,
      input  acs_path_0_valid, acs_path_1_valid,
      input  acs_path_0_bmc, acs_path_1_bmc,
      input  acs_path_0_pmc, acs_path_1_pmc,
      input  surv_valid, surv_sel, surv_vld, best_state
   );

endinterface

// File: rtl/pm_bank.sv
// Ping-pong path-metric storage. Reads both predecessors of a next state
// from the current bank; writes the next bank; on swap, normalises the next
// bank and makes it current.
module pm_bank
   import viterbi_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_i,
   input  logic             swap_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output metric_t          rd_p0_o,
   output metric_t          rd_p1_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  metric_t          wr_data_i
);

   metric_t          bank_q [2][NUM_STATES];
   logic             cur_q;
   logic             nxt_s;
   logic             any_valid_s;
   logic             all_top_s;
   logic             norm_s;
   logic [IDX_W-1:0] p0_s;
   logic [IDX_W-1:0] p1_s;

   assign nxt_s   = ~cur_q;
   assign p0_s    = {1'b0, rd_idx_i[IDX_W-1:1]};
   assign p1_s    = {1'b1, rd_idx_i[IDX_W-1:1]};
   assign rd_p0_o = bank_q[cur_q][p0_s];
   assign rd_p1_o = bank_q[cur_q][p1_s];

   // Normalise when every reachable new metric has its top bit set
   always_comb begin
      any_valid_s = 1'b0;
      all_top_s   = 1'b1;
      for (int s = 0; s < NUM_STATES; s++) begin
         any_valid_s = any_valid_s | bank_q[nxt_s][s].valid;
         all_top_s   = all_top_s & (~bank_q[nxt_s][s].valid | bank_q[nxt_s][s].cost[PM_W-1]);
      end
      norm_s = any_valid_s & all_top_s;
   end

   // Bank storage: init both banks, indexed write, normalise-and-swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < NUM_STATES; s++) begin
               bank_q[b][s] <= init_metric(s);
            end
         end
      end else if (init_i) begin
         cur_q <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < NUM_STATES; s++) begin
               bank_q[b][s] <= init_metric(s);
            end
         end
      end else begin
         if (wr_en_i) begin
            bank_q[nxt_s][wr_idx_i] <= wr_data_i;
         end
         if (swap_i) begin
            for (int s = 0; s < NUM_STATES; s++) begin
               if (norm_s && bank_q[nxt_s][s].valid) begin
                  bank_q[nxt_s][s].cost[PM_W-1] <= 1'b0;
               end
            end
            cur_q <= nxt_s;
         end
      end
   end

endmodule

// File: rtl/acs_scheduler.sv
// Time-shares one external ACS across the 8 trellis states: one accepted
// step walks states 0..7, stores new metrics in the ping-pong bank and
// publishes one survivor word plus the best state.
module acs_scheduler
   import viterbi_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   acs_scheduler_if.slave bus
);

   sched_state_e          state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [3:0][1:0]       bm_q, bm_d;

   logic                  accept_s;
   logic                  step_ready_s;
   logic                  init_s;
   logic                  wr_en_s;
   logic                  swap_s;
   logic                  run_s;
   metric_t               rd_p0_s, rd_p1_s, wr_data_s;
   logic [IDX_W-1:0]      p0_s, p1_s;
   logic                  u_s;

   logic                  surv_valid_q;
   logic [NUM_STATES-1:0] surv_sel_q, surv_vld_q;
   logic [IDX_W-1:0]      best_state_q;
   logic [NUM_STATES-1:0] wsel_q, wvld_q;
   logic [IDX_W-1:0]      best_idx_q;
   logic [PM_W-1:0]       best_cost_q;
   logic                  best_found_q;

   assign p0_s  = {1'b0, idx_q[IDX_W-1:1]};
   assign p1_s  = {1'b1, idx_q[IDX_W-1:1]};
   assign u_s   = idx_q[0];
   assign run_s = (state_q == S_RUN);

   pm_bank u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_i    (init_s),
      .swap_i    (swap_s),
      .rd_idx_i  (idx_q),
      .rd_p0_o   (rd_p0_s),
      .rd_p1_o   (rd_p1_s),
      .wr_en_i   (wr_en_s),
      .wr_idx_i  (idx_q),
      .wr_data_i (wr_data_s)
   );

   // Next-state logic and per-state strobes; start overrides everything
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      bm_d         = bm_q;
      accept_s     = 1'b0;
      step_ready_s = 1'b0;
      init_s       = 1'b0;
      wr_en_s      = 1'b0;
      swap_s       = 1'b0;
      wr_data_s    = '{valid: bus.acs_valid_o, cost: bus.acs_path_cost};
      if (bus.start) begin
         init_s  = 1'b1;
         idx_d   = 3'd0;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               step_ready_s = 1'b1;
               if (bus.step_valid) begin
                  accept_s = 1'b1;
                  bm_d     = bus.bm_i;
                  idx_d    = 3'd0;
                  state_d  = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               wr_en_s = 1'b1;
               if (idx_q == 3'd7) begin
                  state_d = S_COMMIT;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
            S_COMMIT: begin
               swap_s  = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               if (bus.surv_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // FSM state, step index and latched branch metrics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         bm_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bm_q    <= bm_d;
      end
   end

   // Survivor capture in RUN, publication at COMMIT, release in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         surv_valid_q <= 1'b0;
         surv_sel_q   <= 8'h00;
         surv_vld_q   <= 8'h00;
         best_state_q <= 3'd0;
         wsel_q       <= 8'h00;
         wvld_q       <= 8'h00;
         best_idx_q   <= 3'd0;
         best_cost_q  <= 8'h00;
         best_found_q <= 1'b0;
      end else if (bus.start) begin
         surv_valid_q <= 1'b0;
         best_found_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  best_found_q <= 1'b0;
               end
            end
            S_RUN: begin
               wsel_q[idx_q] <= bus.acs_selection;
               wvld_q[idx_q] <= bus.acs_valid_o;
               if (bus.acs_valid_o && (!best_found_q || (bus.acs_path_cost < best_cost_q))) begin
                  best_found_q <= 1'b1;
                  best_idx_q   <= idx_q;
                  best_cost_q  <= bus.acs_path_cost;
               end
            end
            S_COMMIT: begin
               surv_sel_q   <= wsel_q;
               surv_vld_q   <= wvld_q;
               best_state_q <= best_idx_q;
               surv_valid_q <= 1'b1;
            end
            S_DONE: begin
               if (bus.surv_ready) begin
                  surv_valid_q <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Held low while rst_n is asserted even though the FSM already sits in IDLE
   assign bus.step_ready = step_ready_s & rst_n;

   // ACS drive is quiet outside RUN
   assign bus.acs_path_0_valid = run_s & rd_p0_s.valid;
   assign bus.acs_path_1_valid = run_s & rd_p1_s.valid;
   assign bus.acs_path_0_bmc   = run_s ? bm_q[exp_sym(p0_s, u_s)] : 2'b00;
   assign bus.acs_path_1_bmc   = run_s ? bm_q[exp_sym(p1_s, u_s)] : 2'b00;
   assign bus.acs_path_0_pmc   = run_s ? rd_p0_s.cost : 8'h00;
   assign bus.acs_path_1_pmc   = run_s ? rd_p1_s.cost : 8'h00;

   assign bus.surv_valid = surv_valid_q;
   assign bus.surv_sel   = surv_sel_q;
   assign bus.surv_vld   = surv_vld_q;
   assign bus.best_state = best_state_q;

endmodule

// File: tb/tb_acs_scheduler.sv
// Directed self-checking bench for acs_scheduler. Acts as the external ACS,
// keeps an independent trellis model and a survivor scoreboard.
module tb_acs_scheduler;

   typedef logic [3:0][1:0] bm_t;
   typedef struct packed {
      logic [7:0] sel;
      logic [7:0] vld;
      logic [2:0] best;
   } surv_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   acs_scheduler_if bus ();

   acs_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // External ACS model: add-compare-select, ties go to path 0
   logic [7:0] acs_c0, acs_c1;
   assign acs_c0 = bus.acs_path_0_pmc + {6'd0, bus.acs_path_0_bmc};
   assign acs_c1 = bus.acs_path_1_pmc + {6'd0, bus.acs_path_1_bmc};
   assign bus.acs_selection = bus.acs_path_1_valid & (~bus.acs_path_0_valid | (acs_c1 < acs_c0));
   assign bus.acs_valid_o   = bus.acs_path_0_valid | bus.acs_path_1_valid;
   assign bus.acs_path_cost = bus.acs_selection ? acs_c1 : acs_c0;

   // Trellis reference model
   logic       m_v [8];
   logic [7:0] m_c [8];
   logic       e_v0 [8], e_v1 [8];
   logic [1:0] e_b0 [8], e_b1 [8];
   logic [7:0] e_c0 [8], e_c1 [8];
   logic       n_v [8];
   logic [7:0] n_c [8];
   logic [7:0] e_sel, e_vld;
   logic [2:0] e_best;
   bit         norm_hit;
   surv_t      sb_q [$];

   function automatic logic [1:0] tb_sym(input logic [2:0] p, input logic u);
      logic [3:0] r;
      r = {u, p};
      return {^(r & 4'b1111), ^(r & 4'b1101)};
   endfunction

   function automatic bm_t mk_bm(input int a0, input int a1, input int a2, input int a3);
      bm_t b;
      b[0] = 2'(a0);
      b[1] = 2'(a1);
      b[2] = 2'(a2);
      b[3] = 2'(a3);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      for (int s = 0; s < 8; s++) begin
         m_v[s] = (s == 0);
         m_c[s] = 8'd0;
      end
   endtask

   task automatic compute_step(input bm_t bm);
      logic [2:0] n, p0, p1;
      logic       u, sel;
      logic [7:0] s0, s1, bc;
      bit         found, anyv, allt;
      found = 0; anyv = 0; allt = 1; bc = 8'd0;
      e_sel = 8'd0; e_vld = 8'd0; e_best = 3'd0;
      for (int ns = 0; ns < 8; ns++) begin
         n  = ns[2:0];
         p0 = {1'b0, n[2:1]};
         p1 = {1'b1, n[2:1]};
         u  = n[0];
         e_v0[ns] = m_v[p0]; e_c0[ns] = m_c[p0]; e_b0[ns] = bm[tb_sym(p0, u)];
         e_v1[ns] = m_v[p1]; e_c1[ns] = m_c[p1]; e_b1[ns] = bm[tb_sym(p1, u)];
         s0  = e_c0[ns] + {6'd0, e_b0[ns]};
         s1  = e_c1[ns] + {6'd0, e_b1[ns]};
         sel = e_v1[ns] && (!e_v0[ns] || (s1 < s0));
         n_v[ns] = e_v0[ns] | e_v1[ns];
         n_c[ns] = sel ? s1 : s0;
         e_sel[ns] = sel;
         e_vld[ns] = n_v[ns];
         if (n_v[ns] && (!found || n_c[ns] < bc)) begin
            found = 1; bc = n_c[ns]; e_best = n;
         end
         if (n_v[ns]) begin
            anyv = 1;
            allt = allt & n_c[ns][7];
         end
      end
      norm_hit = anyv && allt;
   endtask

   task automatic apply_model();
      for (int s = 0; s < 8; s++) begin
         m_v[s] = n_v[s];
         m_c[s] = n_c[s];
         if (norm_hit && n_v[s]) m_c[s][7] = 1'b0;
      end
   endtask

   task automatic check_run(input int i);
      chk($sformatf("run%0d_v0", i),  32'(bus.acs_path_0_valid), 32'(e_v0[i]));
      chk($sformatf("run%0d_v1", i),  32'(bus.acs_path_1_valid), 32'(e_v1[i]));
      chk($sformatf("run%0d_b0", i),  32'(bus.acs_path_0_bmc),   32'(e_b0[i]));
      chk($sformatf("run%0d_b1", i),  32'(bus.acs_path_1_bmc),   32'(e_b1[i]));
      chk($sformatf("run%0d_pm0", i), 32'(bus.acs_path_0_pmc),   32'(e_c0[i]));
      chk($sformatf("run%0d_pm1", i), 32'(bus.acs_path_1_pmc),   32'(e_c1[i]));
   endtask

   // Offer one step; returns at the negedge of the first DONE cycle (T+10)
   task automatic do_step(input bm_t bm, input bit exp_now);
      bit    acc;
      int    waited;
      surv_t got;
      acc = 0; waited = 0;
      compute_step(bm);
      sb_q.push_back('{sel: e_sel, vld: e_vld, best: e_best});
      @(negedge clk);
      bus.bm_i = bm;
      bus.step_valid = 1'b1;
      if (exp_now) chk("accept_now", 32'(bus.step_ready), 32'd1);
      while (!acc && waited < 40) begin
         if (bus.step_ready) acc = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      chk("accept_seen", 32'(acc), 32'd1);
      @(posedge clk);
      #1;
      bus.step_valid = 1'b0;
      bus.bm_i = ~bm;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_run(i);
      end
      @(negedge clk);
      chk("commit_surv_valid", 32'(bus.surv_valid), 32'd0);
      @(negedge clk);
      chk("surv_valid_t10", 32'(bus.surv_valid), 32'd1);
      if (bus.surv_valid === 1'b1 && sb_q.size() > 0) begin
         got = sb_q.pop_front();
         chk("surv_sel",   32'(bus.surv_sel),   32'(got.sel));
         chk("surv_vld",   32'(bus.surv_vld),   32'(got.vld));
         chk("best_state", 32'(bus.best_state), 32'(got.best));
      end
      apply_model();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_step_ready"}, 32'(bus.step_ready),       32'd0);
      chk({tag, "_surv_valid"}, 32'(bus.surv_valid),       32'd0);
      chk({tag, "_surv_sel"},   32'(bus.surv_sel),         32'd0);
      chk({tag, "_surv_vld"},   32'(bus.surv_vld),         32'd0);
      chk({tag, "_best"},       32'(bus.best_state),       32'd0);
      chk({tag, "_acs_v0"},     32'(bus.acs_path_0_valid), 32'd0);
      chk({tag, "_acs_v1"},     32'(bus.acs_path_1_valid), 32'd0);
      chk({tag, "_acs_pm0"},    32'(bus.acs_path_0_pmc),   32'd0);
      chk({tag, "_acs_b1"},     32'(bus.acs_path_1_bmc),   32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k;
      bm_t bm_a;
      bm_a = mk_bm(0, 1, 1, 2);
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.step_valid = 1'b0;
      bus.bm_i = 8'h00;
      bus.surv_ready = 1'b1;
      model_init();
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 32'(bus.step_ready), 32'd1);

      // First step from the init bank: states 0 (cost 0) and 1 (cost 2)
      do_step(bm_a, 1'b1);
      chk("step1_vld", 32'(bus.surv_vld), 32'h03);
      do_step(mk_bm(2, 0, 3, 1), 1'b0);

      // Reinitialise, then three all-zero steps reach every state at cost 0
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      model_init();
      for (int s = 0; s < 3; s++) do_step(mk_bm(0, 0, 0, 0), 1'b0);
      chk("zero_vld_ff", 32'(bus.surv_vld), 32'hFF);

      // Grow metrics until the normalising commit, then one more step
      k = 0;
      norm_hit = 0;
      while (!norm_hit && k < 200) begin
         do_step(mk_bm(1 + (k % 3), 1 + ((k + 1) % 3), 1 + ((k + 2) % 3), 1 + (k % 2)), 1'b0);
         k++;
      end
      do_step(mk_bm(1, 2, 3, 2), 1'b0);

      // start together with step_valid in IDLE: start wins
      @(negedge clk);
      bus.start = 1'b1;
      bus.step_valid = 1'b1;
      bus.bm_i = bm_a;
      #1;
      chk("start_wins_ready", 32'(bus.step_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.step_valid = 1'b0;
      model_init();
      @(negedge clk);
      chk("start_wins_no_run", 32'(bus.acs_path_0_valid), 32'd0);
      chk("start_wins_idle", 32'(bus.step_ready), 32'd1);

      // Traceback back-pressure: hold surv_ready low for 5 DONE cycles
      bus.surv_ready = 1'b0;
      do_step(mk_bm(3, 1, 0, 2), 1'b0);
      bus.step_valid = 1'b1;
      bus.bm_i = mk_bm(1, 1, 0, 3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.surv_valid), 32'd1);
         chk("hold_sel",   32'(bus.surv_sel),   32'(e_sel));
         chk("hold_vld",   32'(bus.surv_vld),   32'(e_vld));
         chk("hold_best",  32'(bus.best_state), 32'(e_best));
         chk("hold_ready", 32'(bus.step_ready), 32'd0);
      end
      bus.surv_ready = 1'b1;
      do_step(mk_bm(1, 1, 0, 3), 1'b1);

      // Abort with start at RUN idx 4
      compute_step(mk_bm(2, 2, 1, 0));
      @(negedge clk);
      bus.bm_i = mk_bm(2, 2, 1, 0);
      bus.step_valid = 1'b1;
      chk("abort_accept_ready", 32'(bus.step_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.step_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_run(i);
      end
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_acs_off", 32'(bus.acs_path_0_valid), 32'd0);
      chk("abort_ready_start", 32'(bus.step_ready), 32'd0);
      bus.start = 1'b0;
      #1;
      chk("abort_idle", 32'(bus.step_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_surv", 32'(bus.surv_valid), 32'd0);
      end
      model_init();
      do_step(bm_a, 1'b1);
      chk("abort_init_vld", 32'(bus.surv_vld), 32'h03);

      // A few mixed steps, then async reset in the middle of RUN
      do_step(mk_bm(3, 0, 2, 1), 1'b0);
      do_step(mk_bm(0, 3, 1, 2), 1'b0);
      compute_step(mk_bm(1, 0, 2, 3));
      @(negedge clk);
      bus.bm_i = mk_bm(1, 0, 2, 3);
      bus.step_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.step_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_run(i);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("async_rst_idle", 32'(bus.step_ready), 32'd1);
      model_init();
      do_step(bm_a, 1'b1);
      chk("async_rst_init_vld", 32'(bus.surv_vld), 32'h03);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
